// File: rtl/fp_add_arb_pkg.sv
// Shared types and field widths for the FP32 adder arbiter.
package fp_add_arb_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int FP_W  = 1 + EXP_W + MAN_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC1 = 2'd1,
    EXEC2 = 2'd2,
    DONE  = 2'd3
  } arbStateT;

endpackage

// File: rtl/fp_add_arbiter_if.sv
// Request/result bus and adder hookup for the shared FP32 adder arbiter.
// The arbiter uses the slave modport; clients and the adder sit on master.
interface fp_add_arbiter_if
  import fp_add_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = FP_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;

  logic [WIDTH-1:0]         add_a;
  logic [WIDTH-1:0]         add_b;
  logic                     add_sign;
  logic [EXP_W-1:0]         add_exp;
  logic [MAN_W-1:0]         add_man;

  logic                     res_valid;
  logic                     res_ready;
  logic [WIDTH-1:0]         res_data;
  logic [ID_W-1:0]          res_id;
  logic                     busy;

  modport slave (
    input  req_valid, req_a, req_b, add_sign, add_exp, add_man, res_ready,
    output req_ready, add_a, add_b, res_valid, res_data, res_id, busy
  );

  modport master (
    output req_valid, req_a, req_b, add_sign, add_exp, add_man, res_ready,
    input  req_ready, add_a, add_b, res_valid, res_data, res_id, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping past N-1 back to 0.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            any
);

  // scan N positions starting at ptr, keep the first hit
  always_comb begin
    int cand;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!any && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = ID_W'(cand);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Time-shares one 2-stage FP32 adder between NUM_REQ clients.
// State table:
//   IDLE  | waiting for a request; req_ready carries the one-hot grant
//   EXEC1 | operands on add_a/add_b, adder stage 1 captures at cycle end
//   EXEC2 | operands held (stage-2 sign reads them live), result captured
//   DONE  | res_valid high until the consumer takes the result
module fp_add_arbiter
  import fp_add_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = FP_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic          clk_n,
  input  logic          rst_n,
  fp_add_arbiter_if.slave bus
);

  arbStateT           state;
  arbStateT           nextState;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gntIdx;
  logic               anyReq;

  logic [ID_W-1:0]    rrPtr;
  logic [ID_W-1:0]    idQ;
  logic [WIDTH-1:0]   opA;
  logic [WIDTH-1:0]   opB;
  logic [WIDTH-1:0]   selA;
  logic [WIDTH-1:0]   selB;
  logic [WIDTH-1:0]   resData;
  logic [ID_W-1:0]    resId;

  logic [NUM_REQ-1:0] reqReady;
  logic               handshake;
  logic               isBusy;
  logic               resValid;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) uArb (
    .req     (bus.req_valid),
    .ptr     (rrPtr),
    .gnt     (gnt),
    .gnt_idx (gntIdx),
    .any     (anyReq)
  );

  // state register
  always_ff @(posedge clk_n or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // next-state decode
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (anyReq) nextState = EXEC1;
      EXEC1:   nextState = EXEC2;
      EXEC2:   nextState = DONE;
      DONE:    if (bus.res_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // state-decoded outputs; grant is masked while reset is held so the
  // handshake lines read zero the moment reset asserts
  always_comb begin
    reqReady  = '0;
    handshake = 1'b0;
    isBusy    = 1'b1;
    resValid  = 1'b0;
    unique case (state)
      IDLE: begin
        isBusy    = 1'b0;
        handshake = anyReq;
        if (rst_n) reqReady = gnt;
      end
      DONE:    resValid = 1'b1;
      default: ;
    endcase
  end

  // mux the granted requester's operands out of the packed buses
  always_comb begin
    selA = '0;
    selB = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gntIdx == ID_W'(i)) begin
        selA = bus.req_a[i*WIDTH +: WIDTH];
        selB = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // latch operands, tag and advance the rotation pointer at the handshake
  always_ff @(posedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      opA   <= '0;
      opB   <= '0;
      idQ   <= '0;
      rrPtr <= '0;
    end else if (handshake) begin
      opA   <= selA;
      opB   <= selB;
      idQ   <= gntIdx;
      rrPtr <= (gntIdx == ID_W'(NUM_REQ-1)) ? '0 : gntIdx + ID_W'(1);
    end
  end

  // capture adder output at the end of the second execute cycle
  always_ff @(posedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      resData <= '0;
      resId   <= '0;
    end else if (state == EXEC2) begin
      resData <= WIDTH'({bus.add_sign, bus.add_exp, bus.add_man});
      resId   <= idQ;
    end
  end

  // operand registers feed the adder directly, so add_a/add_b hold their
  // last value between operations
  assign bus.add_a     = opA;
  assign bus.add_b     = opB;
  assign bus.req_ready = reqReady;
  assign bus.res_valid = resValid;
  assign bus.res_data  = resData;
  assign bus.res_id    = resId;
  assign bus.busy      = isBusy;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: stand-in 2-stage adder, transaction-level
// reference model with a per-cycle compare, plus directed scenarios.
module tb_fp_add_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;

  logic clk_n = 1'b0;
  logic rst_n = 1'b0;

  fp_add_arbiter_if #(.NUM_REQ(NREQ), .WIDTH(W), .ID_W(IDW)) bus ();

  fp_add_arbiter #(.NUM_REQ(NREQ), .WIDTH(W), .ID_W(IDW)) dut (
    .clk_n (clk_n),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_n = ~clk_n;

  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;
  bit chkEn  = 1'b0;

  always @(posedge clk_n) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // stand-in adder: a few true FP32 sums, a reversible scramble otherwise
  function automatic logic [31:0] fakeAdd(logic [31:0] a, logic [31:0] b);
    if ((a == 32'h3F800000 && b == 32'h40000000) || (a == 32'h40000000 && b == 32'h3F800000))
      return 32'h40400000;
    if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
    if (a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    if ((a == 32'h40400000 && b == 32'h3F800000) || (a == 32'h3F800000 && b == 32'h40400000))
      return 32'h40800000;
    return {a[31], a[30:0] ^ {b[15:0], b[30:16]}};
  endfunction

  // stage 1 registers exp/man; sign comes from the live operands
  logic [31:0] stage1 = '0;
  logic [31:0] liveSum;
  always @(posedge clk_n) stage1 <= fakeAdd(bus.add_a, bus.add_b);
  assign liveSum      = fakeAdd(bus.add_a, bus.add_b);
  assign bus.add_sign = liveSum[31];
  assign bus.add_exp  = stage1[30:23];
  assign bus.add_man  = stage1[22:0];

  function automatic int pick(logic [NREQ-1:0] v, int ptr);
    for (int i = 0; i < NREQ; i++) begin
      if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic int onehotIdx(logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // reference model: one outstanding op, age = edges since its handshake
  bit          mOut    = 1'b0;
  int          mAge    = 0;
  int          mPtr    = 0;
  int          mId     = 0;
  int          lastId  = 0;
  logic [31:0] mA      = '0;
  logic [31:0] mB      = '0;
  logic [31:0] lastRes = '0;

  always @(posedge clk_n or negedge rst_n) begin
    int g;
    if (!rst_n) begin
      mOut <= 1'b0; mAge <= 0; mPtr <= 0; mId <= 0;
      mA <= '0; mB <= '0; lastRes <= '0; lastId <= 0;
    end else if (mOut) begin
      if (mAge >= 2 && bus.res_ready) mOut <= 1'b0;
      else begin
        mAge <= mAge + 1;
        if (mAge == 1) begin
          lastRes <= fakeAdd(mA, mB);
          lastId  <= mId;
        end
      end
    end else begin
      g = pick(bus.req_valid, mPtr);
      if (g >= 0) begin
        mOut <= 1'b1;
        mAge <= 0;
        mA   <= bus.req_a[g*W +: W];
        mB   <= bus.req_b[g*W +: W];
        mId  <= g;
        mPtr <= (g + 1) % NREQ;
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk_n) begin
    logic [NREQ-1:0] er;
    int g;
    if (chkEn) begin
      er = '0;
      if (rst_n && !mOut) begin
        g = pick(bus.req_valid, mPtr);
        if (g >= 0) er[g] = 1'b1;
      end
      check("cmp_req_ready", 32'(bus.req_ready), 32'(er));
      check("cmp_busy", 32'(bus.busy), 32'(mOut));
      check("cmp_res_valid", 32'(bus.res_valid), 32'(mOut && mAge >= 2));
      check("cmp_add_a", bus.add_a, mA);
      check("cmp_add_b", bus.add_b, mB);
      check("cmp_res_data", bus.res_data, lastRes);
      check("cmp_res_id", 32'(bus.res_id), 32'(lastId));
    end
  end

  // delivered result tags, recorded during the rotation scenario
  bit rrRec = 1'b0;
  int idQueue[$];
  always @(negedge clk_n) begin
    if (rrRec && bus.res_valid && bus.res_ready) idQueue.push_back(int'(bus.res_id));
  end

  task automatic waitGrant(input string name, output int idx);
    idx = -1;
    for (int c = 0; c < 40 && idx < 0; c++) begin
      @(negedge clk_n);
      if (bus.req_ready != '0) idx = onehotIdx(bus.req_ready);
    end
    if (idx < 0) begin
      nTests++;
      nFail++;
      $display("FAIL %s: no grant seen within 40 cycles", name);
    end
  endtask

  initial begin
    #200000;
    nFail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    int g;
    int prevCyc;
    int expOrder[5] = '{0, 1, 2, 3, 0};
    bit seen;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b0;

    // reset, with a request already pending to prove grant is masked
    repeat (2) @(posedge clk_n);
    #1;
    chkEn = 1'b1;
    bus.req_a[2*W +: W] = 32'h3F800000;
    bus.req_b[2*W +: W] = 32'h40000000;
    bus.req_valid       = 4'b0100;
    @(negedge clk_n);
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_res_valid", 32'(bus.res_valid), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    @(posedge clk_n); #1;
    rst_n = 1'b1;

    // single op from requester 2
    @(negedge clk_n);
    check("single_grant", 32'(bus.req_ready), 32'h4);
    @(posedge clk_n); #1;
    bus.req_valid = '0;
    @(negedge clk_n);
    check("single_busy", 32'(bus.busy), 32'h1);
    check("single_add_a", bus.add_a, 32'h3F800000);
    @(negedge clk_n);
    check("single_early_valid", 32'(bus.res_valid), 32'h0);
    check("single_add_b", bus.add_b, 32'h40000000);
    @(negedge clk_n);
    check("single_res_valid", 32'(bus.res_valid), 32'h1);
    check("single_res_data", bus.res_data, 32'h40400000);
    check("single_res_id", 32'(bus.res_id), 32'h2);
    bus.res_ready = 1'b1;
    @(negedge clk_n);
    check("single_busy_after", 32'(bus.busy), 32'h0);

    // pointer wrap: ptr is 3, only requesters 0 and 3 ask
    @(posedge clk_n); #1;
    bus.req_a[0*W +: W] = 32'h12345678; bus.req_b[0*W +: W] = 32'h0F0F0F0F;
    bus.req_a[3*W +: W] = 32'h40400000; bus.req_b[3*W +: W] = 32'h3F800000;
    bus.req_valid = 4'b1001;
    waitGrant("wrap_first", g);
    check("wrap_first", 32'(g), 32'd3);
    @(posedge clk_n);
    waitGrant("wrap_second", g);
    check("wrap_second", 32'(g), 32'd0);
    @(posedge clk_n); #1;
    bus.req_valid = '0;
    repeat (5) @(posedge clk_n);
    #1;

    // backpressure on requester 2 while requester 0 waits
    bus.res_ready = 1'b0;
    bus.req_a[2*W +: W] = 32'h40000000;
    bus.req_b[2*W +: W] = 32'h40000000;
    bus.req_valid = 4'b0100;
    waitGrant("bp_grant", g);
    check("bp_grant", 32'(g), 32'd2);
    @(posedge clk_n); #1;
    bus.req_valid = 4'b0001;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk_n);
      seen = bus.res_valid;
    end
    if (!seen) begin
      nTests++; nFail++;
      $display("FAIL bp_wait: res_valid not seen within 10 cycles");
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk_n);
      check("bp_res_valid", 32'(bus.res_valid), 32'h1);
      check("bp_res_data", bus.res_data, 32'h40800000);
      check("bp_res_id", 32'(bus.res_id), 32'h2);
      check("bp_req_ready", 32'(bus.req_ready), 32'h0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk_n); #1;
    bus.res_ready = 1'b0;
    @(negedge clk_n);
    check("bp_release_busy", 32'(bus.busy), 32'h0);
    check("bp_release_grant", 32'(bus.req_ready), 32'h1);
    @(posedge clk_n); #1;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    repeat (5) @(posedge clk_n);
    #1;

    // operand hold: requester 1 changes A right after its handshake
    bus.req_a[1*W +: W] = 32'h3F800000;
    bus.req_b[1*W +: W] = 32'h3F800000;
    bus.req_valid = 4'b0010;
    waitGrant("hold_grant", g);
    check("hold_grant", 32'(g), 32'd1);
    @(posedge clk_n); #1;
    bus.req_a[1*W +: W] = 32'hBF800000;
    bus.req_valid = '0;
    @(negedge clk_n);
    check("hold_exec1_add_a", bus.add_a, 32'h3F800000);
    @(negedge clk_n);
    check("hold_exec2_add_a", bus.add_a, 32'h3F800000);
    @(negedge clk_n);
    check("hold_res_data", bus.res_data, 32'h40000000);
    check("hold_res_id", 32'(bus.res_id), 32'h1);
    repeat (3) @(posedge clk_n);
    #1;

    // reset during EXEC2
    bus.req_a[1*W +: W] = 32'h40400000;
    bus.req_b[1*W +: W] = 32'h3F800000;
    bus.req_valid = 4'b0010;
    waitGrant("rst_mid_grant", g);
    check("rst_mid_grant", 32'(g), 32'd1);
    @(posedge clk_n); #1;
    bus.req_a[0*W +: W] = 32'h41000000; bus.req_b[0*W +: W] = 32'h40000000;
    bus.req_a[1*W +: W] = 32'h41000001; bus.req_b[1*W +: W] = 32'h40000010;
    bus.req_a[2*W +: W] = 32'h41000002; bus.req_b[2*W +: W] = 32'h40000020;
    bus.req_a[3*W +: W] = 32'h41000003; bus.req_b[3*W +: W] = 32'h40000030;
    bus.req_valid = 4'b1111;
    @(posedge clk_n); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(bus.busy), 32'h0);
    check("rst_mid_res_valid", 32'(bus.res_valid), 32'h0);
    check("rst_mid_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_mid_add_a", bus.add_a, 32'h0);
    check("rst_mid_add_b", bus.add_b, 32'h0);
    check("rst_mid_res_data", bus.res_data, 32'h0);
    check("rst_mid_res_id", 32'(bus.res_id), 32'h0);
    @(posedge clk_n); #1;
    rst_n = 1'b1;

    // all four requesters held valid: rotation 0,1,2,3,0, four cycles apart
    rrRec   = 1'b1;
    prevCyc = 0;
    for (int i = 0; i < 5; i++) begin
      waitGrant("rr_grant", g);
      check("rr_grant", 32'(g), 32'(expOrder[i]));
      if (i > 0) check("rr_spacing", 32'(cyc - prevCyc), 32'd4);
      prevCyc = cyc;
      @(posedge clk_n);
    end
    #1;
    bus.req_valid = '0;
    repeat (6) @(posedge clk_n);
    rrRec = 1'b0;
    check("rr_id_count", 32'(idQueue.size()), 32'd5);
    for (int i = 0; i < 5 && i < idQueue.size(); i++) begin
      check("rr_res_id", 32'(idQueue[i]), 32'(expOrder[i]));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
